// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux_arbiter_if : requester/mux handshake and data bundle for mux_arbiter
// Rev 1.0 - initial release
// ============================================================================
interface mux_arbiter_if #(
  parameter int WIDTH = 1
);

  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  // Requester/stimulus side drives requests and data.
  modport master (
    output req_a, req_b, data_a, data_b,
    input  grant_a, grant_b, sel, dout, dout_valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output grant_a, grant_b, sel, dout, dout_valid
  );

endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// mux_arbiter : two-requester round-robin arbiter with hold limit and
//               registered 2:1 mux output stage
// Rev 1.0 - initial release
// ============================================================================
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  wire logic    clock,
  input  wire logic    reset_n,
  mux_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic             C_LAST_A    = 1'b0;
  localparam logic             C_LAST_B    = 1'b1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             grant_a_q, grant_b_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             xfer;

  assign xfer = (grant_a_q & bus.req_a) | (grant_b_q & bus.req_b);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          state_d = (last_q == C_LAST_A) ? GNT_B : GNT_A;
        end else if (bus.req_a) begin
          state_d = GNT_A;
        end else if (bus.req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (!bus.req_a) begin
          state_d = bus.req_b ? GNT_B : IDLE;
        end else if (bus.req_b && (hold_cnt_q == C_HOLD_LAST)) begin
          state_d = GNT_B;
        end
      end
      GNT_B: begin
        if (!bus.req_b) begin
          state_d = bus.req_a ? GNT_A : IDLE;
        end else if (bus.req_a && (hold_cnt_q == C_HOLD_LAST)) begin
          state_d = GNT_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every grant entry and saturates, so a lone requester never rotates.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_d == IDLE) || (state_d != state_q)) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != C_HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    last_d = last_q;
    sel_d  = sel_q;
    if (state_d == GNT_A) begin
      last_d = C_LAST_A;
      sel_d  = 1'b0;
    end else if (state_d == GNT_B) begin
      last_d = C_LAST_B;
      sel_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_q       <= C_LAST_B;
      sel_q        <= 1'b0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      grant_a_q    <= (state_d == GNT_A);
      grant_b_q    <= (state_d == GNT_B);
      dout_valid_q <= xfer;
      if (xfer) begin
        dout_q <= sel_q ? bus.data_b : bus.data_a;
      end
    end
  end

  assign bus.grant_a    = grant_a_q;
  assign bus.grant_b    = grant_b_q;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_arbiter : directed self-checking bench for mux_arbiter
// Rev 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  always #5 clock = ~clock;

  mux_arbiter_if #(.WIDTH(4)) if0 ();
  mux_arbiter_if #(.WIDTH(1)) if1 ();

  mux_arbiter #(.WIDTH(4), .MAX_HOLD(4), .CNT_W(3)) u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if0)
  );

  mux_arbiter #(.WIDTH(1), .MAX_HOLD(1), .CNT_W(3)) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp0(input string tag, input logic ga, input logic gb, input logic s,
                      input logic dv, input logic [3:0] d);
    chk({tag, ".grant_a"},    32'(if0.grant_a),    32'(ga));
    chk({tag, ".grant_b"},    32'(if0.grant_b),    32'(gb));
    chk({tag, ".sel"},        32'(if0.sel),        32'(s));
    chk({tag, ".dout_valid"}, 32'(if0.dout_valid), 32'(dv));
    chk({tag, ".dout"},       32'(if0.dout),       32'(d));
  endtask

  task automatic exp1(input string tag, input logic ga, input logic gb, input logic s,
                      input logic dv, input logic d);
    chk({tag, ".grant_a"},    32'(if1.grant_a),    32'(ga));
    chk({tag, ".grant_b"},    32'(if1.grant_b),    32'(gb));
    chk({tag, ".sel"},        32'(if1.sel),        32'(s));
    chk({tag, ".dout_valid"}, 32'(if1.dout_valid), 32'(dv));
    chk({tag, ".dout"},       32'(if1.dout),       32'(d));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic       ga_e;
    logic       prev_sel;
    logic [3:0] d_e;

    // Reset held with both sides requesting.
    reset_n = 1'b0;
    if0.req_a = 1'b1; if0.req_b = 1'b1; if0.data_a = 4'h1; if0.data_b = 4'h1;
    if1.req_a = 1'b1; if1.req_b = 1'b1; if1.data_a = 1'b1; if1.data_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp0($sformatf("rst%0d", i), 0, 0, 0, 0, 4'h0);
    end

    reset_n = 1'b1;
    if0.req_a = 1'b0; if0.req_b = 1'b0;
    if1.req_a = 1'b0; if1.req_b = 1'b0;
    step();
    exp0("idle0", 0, 0, 0, 0, 4'h0);

    // Lone requester A for 10 cycles.
    if0.req_a = 1'b1; if0.data_a = 4'h1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp0($sformatf("lone%0d", e), 1, 0, 0, e > 1, (e > 1) ? 4'h1 : 4'h0);
    end
    if0.req_a = 1'b0;
    step();
    exp0("lone_drop", 0, 0, 0, 0, 4'h1);

    // Short reset so that A wins the next tie.
    reset_n = 1'b0;
    step();
    exp0("rst_b", 0, 0, 0, 0, 4'h0);

    // Contention with MAX_HOLD = 4.
    reset_n = 1'b1;
    if0.req_a = 1'b1; if0.req_b = 1'b1; if0.data_a = 4'h3; if0.data_b = 4'hC;
    prev_sel = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      ga_e = (e <= 4) || (e >= 9);
      d_e  = (e > 1) ? (prev_sel ? 4'hC : 4'h3) : 4'h0;
      exp0($sformatf("cont%0d", e), ga_e, !ga_e, !ga_e, e > 1, d_e);
      prev_sel = !ga_e;
    end

    // Both drop: IDLE, no transfer, sel and dout hold.
    if0.req_a = 1'b0; if0.req_b = 1'b0;
    step();
    exp0("idle2", 0, 0, 0, 0, 4'h3);

    // Handover A -> B before the hold limit.
    if0.req_a = 1'b1; if0.data_a = 4'h5; if0.data_b = 4'hA;
    step();
    exp0("ho_a0", 1, 0, 0, 0, 4'h3);
    if0.req_b = 1'b1;
    step();
    exp0("ho_a1", 1, 0, 0, 1, 4'h5);
    if0.req_a = 1'b0;
    step();
    exp0("ho_n1", 0, 1, 1, 0, 4'h5);
    step();
    exp0("ho_n2", 0, 1, 1, 1, 4'hA);

    // Reset mid-grant while in GNT_B.
    if0.req_a = 1'b1;
    reset_n = 1'b0;
    step();
    exp0("rst_mid", 0, 0, 0, 0, 4'h0);
    reset_n = 1'b1;
    step();
    exp0("post_rst1", 1, 0, 0, 0, 4'h0);
    step();
    exp0("post_rst2", 1, 0, 0, 1, 4'h5);
    if0.req_a = 1'b0; if0.req_b = 1'b0;

    // MAX_HOLD = 1 instance: grants alternate every cycle.
    if1.req_a = 1'b1; if1.req_b = 1'b1; if1.data_a = 1'b0; if1.data_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp1($sformatf("alt%0d", e), (e % 2) == 1, (e % 2) == 0, (e % 2) == 0,
           e > 1, (e > 1) && ((e % 2) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter that drives the `sel` input of the shared 2:1 mux datapath.
- It grants the mux to requester A or requester B and bounds each grant with a hold counter, so neither side can starve the other.
- The selected data is registered onto `dout` with a valid flag, the same way the downstream DFF stage captures it.
- It sits between the two stimulus/requester blocks and the mux/DFF pair.

Parameters:
- WIDTH, 1: data width of data_a, data_b and dout.
- MAX_HOLD, 4: maximum consecutive grant cycles while the other side is requesting. Must be >= 1.
- CNT_W, 3: hold counter width. Must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clock  input  1  system clock; all logic on the posedge.
- reset_n  input  1  synchronous reset, active low.
- req_a  input  1  requester A wants the mux.
- req_b  input  1  requester B wants the mux.
- data_a  input  WIDTH  requester A data.
- data_b  input  WIDTH  requester B data.
- grant_a  output  1  A owns the mux (registered).
- grant_b  output  1  B owns the mux (registered).
- sel  output  1  mux select: 0 selects A, 1 selects B (registered).
- dout  output  WIDTH  registered mux output.
- dout_valid  output  1  dout updated at the last edge.

Behaviour:
- Reset: reset_n low at a posedge is required to produce all of the following, regardless of the req inputs:
  - state = IDLE; grant_a = grant_b = 0; sel = 0.
  - dout = 0; dout_valid = 0; hold_cnt = 0.
  - last = B, so A wins the first tie.
- Reset mid-grant: the same values at the next edge. No transfer occurs in that cycle.
- States: IDLE, GNT_A, GNT_B. grant_a = (state == GNT_A) and grant_b = (state == GNT_B); they are never both 1.
- IDLE transitions:
  - req_a & req_b: go to the side not equal to `last`.
  - Otherwise: go to the requesting side.
  - No request: stay in IDLE.
  - Latency from req to grant is 1 cycle.
- GNT_A transitions (GNT_B is symmetric):
  - !req_a & req_b: go to GNT_B. Handover is back-to-back with no IDLE bubble.
  - !req_a & !req_b: go to IDLE.
  - req_a & req_b & hold_cnt == MAX_HOLD-1: go to GNT_B (forced rotation).
  - req_a & !req_b: stay. hold_cnt saturates at MAX_HOLD-1, so there is no wrap and no rotation.
- hold_cnt:
  - Cleared to 0 on entry to any grant state, so the first grant cycle has hold_cnt = 0.
  - Increments by 1 each cycle the state is unchanged; saturating.
  - Unused in IDLE, where it is held at 0.
- On entry to a grant state: last = the granted side; sel = 0 for GNT_A, 1 for GNT_B.
- In IDLE, sel holds its previous value, so the mux input is stable.
- Transfer:
  - A transfer happens in a cycle where (grant_a & req_a) | (grant_b & req_b).
  - At the next edge: dout <= (sel ? data_b : data_a) and dout_valid <= 1.
  - Otherwise dout_valid <= 0 and dout holds its value.
  - Latency from data to dout is 1 cycle.
- Simultaneous events:
  - A req dropping in the same cycle the hold limit is reached is handled by the !req rule.
  - A grant cycle whose requester has just dropped req produces no transfer.
- MAX_HOLD = 1: when both sides request, the grant alternates every cycle.

Test Plan:
- Reset: reset_n = 0 for 3 cycles with req_a = req_b = 1, data = 1 -> at every edge: grant_a = grant_b = 0, sel = 0, dout = 0, dout_valid = 0.
- Lone requester: after reset, req_a = 1 and data_a = 1 held for 10 cycles ->
  - grant_a = 1 from edge 1.
  - dout = 1 and dout_valid = 1 from edge 2.
  - grant_b stays 0 throughout; there is no rotation.
- Contention, MAX_HOLD = 4: both requesting from IDLE ->
  - grant_a for edges 1–4, grant_b for 5–8, grant_a for 9–12.
  - sel follows 0 / 1 / 0.
  - Never both grants high, and never neither while requests are present.
- Handover: in GNT_A with req_b = 1, req_a drops at cycle n ->
  - grant_b = 1 and sel = 1 at edge n+1.
  - dout_valid = 0 at edge n+1.
  - dout = data_b at edge n+2.
- Reset mid-grant: reset_n = 0 for 1 cycle while in GNT_B ->
  - All outputs reach reset values at the next edge.
  - After release with both requesting, grant_a wins first.
- Instance with MAX_HOLD = 1: both requesting -> grant_a and grant_b alternate every cycle, and dout alternates between data_a and data_b (e.g. 0 and 1).
